// File: rtl/bp_be_issue_queue_pkg.sv
// bp_be_issue_queue_pkg: FE queue message, BE issue packet and RV64 opcode constants shared by the issue queue
package bp_be_issue_queue_pkg;

   localparam int vaddr_width_gp               = 39;
   localparam int branch_metadata_fwd_width_gp = 36;

   typedef enum logic {
      e_fe_msg_fetch     = 1'b0,
      e_fe_msg_exception = 1'b1
   } bp_fe_queue_type_e;

   typedef enum logic [1:0] {
      e_itlb_miss          = 2'd0,
      e_instr_page_fault   = 2'd1,
      e_instr_access_fault = 2'd2,
      e_illegal_instr      = 2'd3
   } bp_fe_exception_code_e;

   // pc carries the faulting vaddr for exception messages
   typedef struct packed {
      bp_fe_queue_type_e                       msg_type;
      logic [vaddr_width_gp-1:0]               pc;
      logic [31:0]                             instr;
      logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
      bp_fe_exception_code_e                   exception_code;
   } bp_fe_queue_s;

   typedef struct packed {
      logic [vaddr_width_gp-1:0]               pc;
      logic [31:0]                             instr;
      logic [branch_metadata_fwd_width_gp-1:0] branch_metadata_fwd;
      logic                                    fe_exception_not_instr;
      bp_fe_exception_code_e                   fe_exception_code;
      logic                                    mem_v;
      logic                                    fence_v;
      logic                                    irs1_v;
      logic                                    irs2_v;
      logic                                    frs1_v;
      logic                                    frs2_v;
   } bp_be_issue_pkt_s;

   localparam int fe_queue_width_gp  = $bits(bp_fe_queue_s);
   localparam int issue_pkt_width_gp = $bits(bp_be_issue_pkt_s);

   localparam logic [6:0] rv64_load_op_gp      = 7'b0000011;
   localparam logic [6:0] rv64_misc_mem_op_gp  = 7'b0001111;
   localparam logic [6:0] rv64_op_imm_op_gp    = 7'b0010011;
   localparam logic [6:0] rv64_op_imm_32_op_gp = 7'b0011011;
   localparam logic [6:0] rv64_store_op_gp     = 7'b0100011;
   localparam logic [6:0] rv64_amo_op_gp       = 7'b0101111;
   localparam logic [6:0] rv64_op_op_gp        = 7'b0110011;
   localparam logic [6:0] rv64_op_32_op_gp     = 7'b0111011;
   localparam logic [6:0] rv64_branch_op_gp    = 7'b1100011;
   localparam logic [6:0] rv64_jalr_op_gp      = 7'b1100111;
   localparam logic [6:0] rv64_system_op_gp    = 7'b1110011;
   localparam logic [6:0] rv64_sfence_vma_f7_gp = 7'b0001001;

endpackage

// File: rtl/bp_be_issue_predecode.sv
// bp_be_issue_predecode: combinational FE queue message -> BE issue packet translation
module bp_be_issue_predecode
   import bp_be_issue_queue_pkg::*;
  (input  bp_fe_queue_s     fe_queue_i,
   output bp_be_issue_pkt_s issue_pkt_o);

   logic [6:0] w_op;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   assign w_op     = fe_queue_i.instr[6:0];
   assign w_funct3 = fe_queue_i.instr[14:12];
   assign w_funct7 = fe_queue_i.instr[31:25];

   // Exceptions carry only pc/code; fetches copy payload and flag operand/unit usage
   always_comb begin
      issue_pkt_o    = '0;
      issue_pkt_o.pc = fe_queue_i.pc;
      if (fe_queue_i.msg_type == e_fe_msg_exception) begin
         issue_pkt_o.fe_exception_not_instr = 1'b1;
         issue_pkt_o.fe_exception_code      = fe_queue_i.exception_code;
      end else begin
         issue_pkt_o.instr               = fe_queue_i.instr;
         issue_pkt_o.branch_metadata_fwd = fe_queue_i.branch_metadata_fwd;
         issue_pkt_o.mem_v   = w_op inside {rv64_load_op_gp, rv64_store_op_gp, rv64_amo_op_gp};
         issue_pkt_o.fence_v = ((w_op == rv64_misc_mem_op_gp) & (w_funct3 inside {3'b000, 3'b001}))
                             | ((w_op == rv64_system_op_gp) & (w_funct3 == 3'b000)
                                & (w_funct7 == rv64_sfence_vma_f7_gp));
         issue_pkt_o.irs1_v  = w_op inside {rv64_jalr_op_gp, rv64_load_op_gp, rv64_op_imm_op_gp,
                                            rv64_op_imm_32_op_gp, rv64_system_op_gp, rv64_branch_op_gp,
                                            rv64_store_op_gp, rv64_op_op_gp, rv64_op_32_op_gp,
                                            rv64_amo_op_gp};
         issue_pkt_o.irs2_v  = w_op inside {rv64_branch_op_gp, rv64_store_op_gp, rv64_op_op_gp,
                                            rv64_op_32_op_gp, rv64_amo_op_gp};
      end
   end

endmodule

// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: replayable issue buffer with commit tracking; BP_BE_ISSUE_QUEUE_BYPASS_EN enables empty-queue bypass
module bp_be_issue_queue
   import bp_be_issue_queue_pkg::*;
 #(parameter  int els_p        = 4,
   localparam int ptr_width_lp = $clog2(els_p))
  (input  logic                  clk_i,
   input  logic                  reset_i,
   input  bp_fe_queue_s          fe_queue_i,
   input  logic                  fe_queue_v_i,
   output logic                  fe_queue_ready_o,
   output bp_be_issue_pkt_s      issue_pkt_o,
   output logic                  issue_pkt_v_o,
   input  logic                  issue_pkt_yumi_i,
   input  logic                  cmt_v_i,
   input  logic                  roll_i,
   input  logic                  clr_i,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [ptr_width_lp:0] count_o);

   logic [ptr_width_lp:0] r_wptr, r_rptr, r_cptr;
   logic [ptr_width_lp:0] w_wptr_n, w_rptr_n, w_cptr_n;
   bp_be_issue_pkt_s      r_mem [els_p];
   bp_be_issue_pkt_s      w_pd;
   logic                  w_enq, w_byp, w_rw_eq;

   bp_be_issue_predecode u_predecode (.fe_queue_i(fe_queue_i), .issue_pkt_o(w_pd));

   assign count_o          = r_wptr - r_cptr;
   assign empty_o          = r_wptr == r_cptr;
   assign full_o           = count_o == (ptr_width_lp+1)'(els_p);
   assign fe_queue_ready_o = ~reset_i & ~full_o & ~clr_i & ~roll_i;
   assign w_enq            = fe_queue_v_i & fe_queue_ready_o;
   assign w_rw_eq          = r_rptr == r_wptr;

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
   // An accepted packet into a queue with nothing pending is presented the same cycle
   assign w_byp = w_rw_eq & w_enq;
`else
   assign w_byp = 1'b0;
`endif

   assign issue_pkt_v_o = ~w_rw_eq | w_byp;
   assign issue_pkt_o   = w_byp ? w_pd : r_mem[r_rptr[ptr_width_lp-1:0]];

   // clr wins; roll commits first then rewinds rptr onto the new cptr
   assign w_cptr_n = clr_i ? '0 : r_cptr + (ptr_width_lp+1)'(cmt_v_i);
   assign w_wptr_n = clr_i ? '0 : r_wptr + (ptr_width_lp+1)'(w_enq);
   assign w_rptr_n = clr_i ? '0 : roll_i ? w_cptr_n : r_rptr + (ptr_width_lp+1)'(issue_pkt_yumi_i);

   // Pointer state, asynchronously cleared
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cptr <= '0;
      end else begin
         r_wptr <= w_wptr_n;
         r_rptr <= w_rptr_n;
         r_cptr <= w_cptr_n;
      end
   end

   // Predecoded packet storage, written at wptr on accept
   always_ff @(posedge clk_i) begin
      if (w_enq) r_mem[r_wptr[ptr_width_lp-1:0]] <= w_pd;
   end

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// tb_bp_be_issue_queue: vector tables, corner sequences and randomized traffic against a queue-level model
module tb_bp_be_issue_queue;
   import bp_be_issue_queue_pkg::*;

   localparam int els_lp = 4;

   logic             clk_i = 1'b0;
   logic             reset_i = 1'b0;
   bp_fe_queue_s     fe_queue_i = '0;
   logic             fe_queue_v_i = 1'b0;
   logic             fe_queue_ready_o;
   bp_be_issue_pkt_s issue_pkt_o;
   logic             issue_pkt_v_o;
   logic             issue_pkt_yumi_i = 1'b0;
   logic             cmt_v_i = 1'b0;
   logic             roll_i = 1'b0;
   logic             clr_i = 1'b0;
   logic             empty_o, full_o;
   logic [2:0]       count_o;

   int n_run = 0;
   int n_fail = 0;

   // Model: all held messages oldest first; the first m_iss of them are issued but uncommitted
   bp_fe_queue_s mq[$];
   int           m_iss = 0;

   typedef struct {
      bp_fe_queue_s m;
      logic mem_v, fence_v, irs1_v, irs2_v, ni;
   } vec_t;
   vec_t tbl[8];

   always #5 clk_i = ~clk_i;

   bp_be_issue_queue #(.els_p(els_lp)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
      .issue_pkt_o(issue_pkt_o), .issue_pkt_v_o(issue_pkt_v_o), .issue_pkt_yumi_i(issue_pkt_yumi_i),
      .cmt_v_i(cmt_v_i), .roll_i(roll_i), .clr_i(clr_i),
      .empty_o(empty_o), .full_o(full_o), .count_o(count_o));

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic bp_fe_queue_s fetch(input logic [38:0] pc, input logic [31:0] instr);
      bp_fe_queue_s m;
      m.msg_type            = e_fe_msg_fetch;
      m.pc                  = pc;
      m.instr               = instr;
      m.branch_metadata_fwd = 36'(pc) ^ 36'hA5A5;
      m.exception_code      = e_itlb_miss;
      return m;
   endfunction

   function automatic bp_fe_queue_s exc(input logic [38:0] vaddr, input bp_fe_exception_code_e code);
      bp_fe_queue_s m;
      m.msg_type            = e_fe_msg_exception;
      m.pc                  = vaddr;
      m.instr               = 32'hFFFF_FFFF;
      m.branch_metadata_fwd = 36'h1_2345;
      m.exception_code      = code;
      return m;
   endfunction

   // Drive one cycle's inputs and compare every output against the model
   task automatic drive(input logic v, input bp_fe_queue_s m, input logic y, input logic c,
                        input logic r, input logic cl);
      logic e_ready, e_v;
      bp_fe_queue_s e_head;
      fe_queue_v_i = v; fe_queue_i = m; issue_pkt_yumi_i = y; cmt_v_i = c; roll_i = r; clr_i = cl;
      #4;
      e_ready = (mq.size() < els_lp) && !cl && !r;
      e_v     = mq.size() > m_iss;
      e_head  = e_v ? mq[m_iss] : m;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
      if (!e_v && v && e_ready) e_v = 1'b1;
`endif
      chk("ready", 64'(fe_queue_ready_o), 64'(e_ready));
      chk("valid", 64'(issue_pkt_v_o), 64'(e_v));
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("full", 64'(full_o), 64'(mq.size() == els_lp));
      chk("empty", 64'(empty_o), 64'(mq.size() == 0));
      if (e_v) begin
         chk("head_pc", 64'(issue_pkt_o.pc), 64'(e_head.pc));
         if (e_head.msg_type == e_fe_msg_fetch) chk("head_instr", 64'(issue_pkt_o.instr), 64'(e_head.instr));
      end
   endtask

   // Advance the model by the inputs just driven, then move past the clock edge
   task automatic tick();
      logic enq;
      enq = fe_queue_v_i && (mq.size() < els_lp) && !clr_i && !roll_i;
      if (clr_i) begin
         mq.delete();
         m_iss = 0;
      end else if (roll_i) begin
         if (cmt_v_i) void'(mq.pop_front());
         m_iss = 0;
      end else begin
         if (issue_pkt_yumi_i) m_iss++;
         if (cmt_v_i) begin
            void'(mq.pop_front());
            m_iss--;
         end
         if (enq) mq.push_back(fe_queue_i);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic step(input logic v, input bp_fe_queue_s m, input logic y, input logic c,
                       input logic r, input logic cl);
      drive(v, m, y, c, r, cl);
      tick();
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tbl[0] = '{fetch(39'h100, 32'h0000A083), 1, 0, 1, 0, 0};
      tbl[1] = '{fetch(39'h104, 32'h0FF0000F), 0, 1, 0, 0, 0};
      tbl[2] = '{exc(39'h1234, e_instr_page_fault), 0, 0, 0, 0, 1};
      tbl[3] = '{fetch(39'h108, 32'h00112023), 1, 0, 1, 1, 0};
      tbl[4] = '{fetch(39'h10C, 32'h002081B3), 0, 0, 1, 1, 0};
      tbl[5] = '{fetch(39'h110, 32'h12000073), 0, 1, 1, 0, 0};
      tbl[6] = '{fetch(39'h114, 32'h0000006F), 0, 0, 0, 0, 0};
      tbl[7] = '{fetch(39'h118, 32'h0020A2AF), 1, 0, 1, 1, 0};

      // Reset values without any clock edge
      #1 reset_i = 1'b1;
      #1;
      chk("rst_valid", 64'(issue_pkt_v_o), 64'd0);
      chk("rst_empty", 64'(empty_o), 64'd1);
      chk("rst_full", 64'(full_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_ready", 64'(fe_queue_ready_o), 64'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Fill to full with no yumi
      for (int i = 0; i < 4; i++) step(1, fetch(39'h8000_0000 + 39'(4*i), 32'h13), 0, 0, 0, 0);
      idle();
      chk("fill_full", 64'(full_o), 64'd1);
      chk("fill_ready", 64'(fe_queue_ready_o), 64'd0);
      chk("fill_count", 64'(count_o), 64'd4);
      tick();

      // Issue three, commit one with roll, replay resumes at the second packet
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
      step(0, '0, 0, 1, 1, 0);
      idle();
      chk("roll_pc", 64'(issue_pkt_o.pc), 64'h8000_0004);
      chk("roll_valid", 64'(issue_pkt_v_o), 64'd1);
      chk("roll_count", 64'(count_o), 64'd3);
      tick();

      // Streaming enqueue + yumi + commit every cycle
      step(0, '0, 0, 0, 0, 1);
      step(1, fetch(39'h1000, 32'h13), 0, 0, 0, 0);
      step(1, fetch(39'h1004, 32'h13), 1, 0, 0, 0);
      for (int k = 0; k < 12; k++) begin
         drive(1, fetch(39'h1008 + 39'(4*k), 32'h13), 1, 1, 0, 0);
         chk("stream_ready", 64'(fe_queue_ready_o), 64'd1);
         chk("stream_pc", 64'(issue_pkt_o.pc), 64'h1004 + 64'(4*k));
         tick();
      end

      // Clear drops the offered packet and all held entries
      step(0, '0, 0, 0, 0, 1);
      step(1, fetch(39'h2000, 32'h13), 0, 0, 0, 0);
      step(1, fetch(39'h2004, 32'h13), 0, 0, 0, 0);
      drive(1, fetch(39'h2008, 32'h13), 0, 0, 0, 1);
      chk("clr_ready", 64'(fe_queue_ready_o), 64'd0);
      tick();
      idle();
      chk("clr_empty", 64'(empty_o), 64'd1);
      chk("clr_valid", 64'(issue_pkt_v_o), 64'd0);
      tick();

      // Predecode vectors, each seen at the head of an otherwise empty queue
      for (int i = 0; i < 8; i++) begin
         step(0, '0, 0, 0, 0, 1);
         step(1, tbl[i].m, 0, 0, 0, 0);
         idle();
         chk($sformatf("pd%0d_mem_v", i), 64'(issue_pkt_o.mem_v), 64'(tbl[i].mem_v));
         chk($sformatf("pd%0d_fence_v", i), 64'(issue_pkt_o.fence_v), 64'(tbl[i].fence_v));
         chk($sformatf("pd%0d_irs1_v", i), 64'(issue_pkt_o.irs1_v), 64'(tbl[i].irs1_v));
         chk($sformatf("pd%0d_irs2_v", i), 64'(issue_pkt_o.irs2_v), 64'(tbl[i].irs2_v));
         chk($sformatf("pd%0d_frs", i), 64'({issue_pkt_o.frs1_v, issue_pkt_o.frs2_v}), 64'd0);
         chk($sformatf("pd%0d_not_instr", i), 64'(issue_pkt_o.fe_exception_not_instr), 64'(tbl[i].ni));
         chk($sformatf("pd%0d_pc", i), 64'(issue_pkt_o.pc), 64'(tbl[i].m.pc));
         chk($sformatf("pd%0d_instr", i), 64'(issue_pkt_o.instr), tbl[i].ni ? 64'd0 : 64'(tbl[i].m.instr));
         chk($sformatf("pd%0d_bmeta", i), 64'(issue_pkt_o.branch_metadata_fwd),
             tbl[i].ni ? 64'd0 : 64'(tbl[i].m.branch_metadata_fwd));
         chk($sformatf("pd%0d_code", i), 64'(issue_pkt_o.fe_exception_code),
             tbl[i].ni ? 64'(tbl[i].m.exception_code) : 64'd0);
         tick();
      end

      // Enqueue into an empty queue: same-cycle visibility only with bypass
      step(0, '0, 0, 0, 0, 1);
      drive(1, fetch(39'h3000, 32'h13), 0, 0, 0, 0);
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
      chk("byp_valid", 64'(issue_pkt_v_o), 64'd1);
      chk("byp_pc", 64'(issue_pkt_o.pc), 64'h3000);
`else
      chk("nobyp_valid", 64'(issue_pkt_v_o), 64'd0);
`endif
      tick();
      step(1, fetch(39'h3004, 32'h13), 0, 0, 0, 0);

      // Asynchronous reset between edges mid-stream
      fe_queue_v_i = 1'b1; fe_queue_i = fetch(39'h3008, 32'h13); issue_pkt_yumi_i = 1'b1;
      #2 reset_i = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(issue_pkt_v_o), 64'd0);
      chk("mid_rst_empty", 64'(empty_o), 64'd1);
      chk("mid_rst_full", 64'(full_o), 64'd0);
      chk("mid_rst_count", 64'(count_o), 64'd0);
      chk("mid_rst_ready", 64'(fe_queue_ready_o), 64'd0);
      fe_queue_v_i = 1'b0; issue_pkt_yumi_i = 1'b0;
      mq.delete();
      m_iss = 0;
      @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic v, y, c, r, cl;
         cl = $urandom_range(0, 99) < 3;
         r  = $urandom_range(0, 99) < 8;
         v  = $urandom_range(0, 99) < 70;
         y  = (mq.size() > m_iss) && ($urandom_range(0, 99) < 60);
         c  = (m_iss > 0) && ($urandom_range(0, 99) < 45);
         step(v, fetch(39'h4000 + 39'(4*n), $urandom), y, c, r, cl);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
